burst_rr_arbiter: RTL and testbench

- Parametrised successor to the 16-bank arbiter. N request channels feed a single write port through round-robin arbitration with burst hold.
- A granted channel keeps the port while it stays valid, up to a programmable burst cap. The port then rotates to the next channel.
- Adds what the 16-bank arbiter lacks: a downstream stall, a burst-length cap, a registered grant ID and zero-bubble hand-over.
- Sits between the per-bank request queues and the command/data write path of the memory-controller back end.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/rr_picker.sv | 32 +++
 rtl/burst_rr_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_burst_rr_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and width helpers for the burst round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_CH    = 16;
  localparam int DEF_REQ_SIZE  = 16;
  localparam int DEF_MAX_BURST = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold the value max_burst itself.
  function automatic int cnt_w(input int max_burst);
    return idx_w(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: first set bit of req searching start, start+1, ... with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
// Ports: req (N) request vector, start (IW) search origin, found flag, idx of the winner.
module rr_picker
  import arb_pkg::*;
#(
  parameter int N  = DEF_NUM_CH,
  parameter int IW = idx_w(DEF_NUM_CH)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(start) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter with burst hold: N request channels share one write port.
// Latency: Ready is combinational; wr_en/Data_out/Grant_id follow one cycle after Ready.
// Backpressure: stall=1 drops Ready and freezes arbitration state; wr_en goes low.
// Ports: clk, rst_n (async active-low), Valid[N], Data_in[N][REQ_SIZE], stall,
//        Ready[N] (Mealy one-hot-or-zero strobe), Data_out, wr_en, Grant_id.
// Build option ARB_URGENT_EN adds Urgent[N]: urgent valid channels win arbitration
// first and cut short a non-urgent burst after its current transfer.
module burst_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int REQ_SIZE  = DEF_REQ_SIZE,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CH-1:0]                  Valid,
  input  logic [NUM_CH-1:0][REQ_SIZE-1:0]    Data_in,
`ifdef ARB_URGENT_EN
  input  logic [NUM_CH-1:0]                  Urgent,
`endif
  input  logic                               stall,
  output logic [NUM_CH-1:0]                  Ready,
  output logic [REQ_SIZE-1:0]                Data_out,
  output logic                               wr_en,
  output logic [idx_w(NUM_CH)-1:0]           Grant_id
);

  localparam int IW = idx_w(NUM_CH);
  localparam int CW = cnt_w(MAX_BURST);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       cur_q, cur_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [REQ_SIZE-1:0] data_out_q, data_out_d;
  logic                wr_en_q, wr_en_d;
  logic [IW-1:0]       grant_id_q, grant_id_d;

  logic [IW-1:0]       cur_inc;
  logic [IW-1:0]       pick_start;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic                rel;
  logic                urg_rel;
  logic                xfer;
  logic [IW-1:0]       sel;
  logic [NUM_CH-1:0]   ready_c;

  assign cur_inc = (cur_q == IW'(NUM_CH - 1)) ? '0 : cur_q + 1'b1;

  // In a burst the only arbitration point is a release, which searches
  // from the channel after the one being released.
  assign pick_start = (state_q == BURST) ? cur_inc : ptr_q;

`ifdef ARB_URGENT_EN
  logic          urg_found, norm_found;
  logic [IW-1:0] urg_idx, norm_idx;
  logic          urg_seen_q, urg_seen_d;
  logic          burst_urg_q, burst_urg_d;

  rr_picker #(.N(NUM_CH), .IW(IW)) u_pick_urg (
    .req   (Urgent & Valid),
    .start (pick_start),
    .found (urg_found),
    .idx   (urg_idx)
  );

  rr_picker #(.N(NUM_CH), .IW(IW)) u_pick_norm (
    .req   (Valid),
    .start (pick_start),
    .found (norm_found),
    .idx   (norm_idx)
  );

  assign pick_found = urg_found | norm_found;
  assign pick_idx   = urg_found ? urg_idx : norm_idx;

  // An urgent request seen last cycle ends a burst that was not itself
  // granted as urgent, so the current transfer completes first.
  assign urg_rel = urg_seen_q && !burst_urg_q;

  always_comb begin
    urg_seen_d  = stall ? urg_seen_q : |(Urgent & Valid);
    burst_urg_d = burst_urg_q;
    if (!stall && (state_q == IDLE || rel) && pick_found) begin
      burst_urg_d = urg_found;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      urg_seen_q  <= 1'b0;
      burst_urg_q <= 1'b0;
    end else begin
      urg_seen_q  <= urg_seen_d;
      burst_urg_q <= burst_urg_d;
    end
  end
`else
  rr_picker #(.N(NUM_CH), .IW(IW)) u_pick (
    .req   (Valid),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign urg_rel = 1'b0;
`endif

  assign rel = (state_q == BURST) &&
               (!Valid[cur_q] || (cnt_q == CW'(MAX_BURST)) || urg_rel);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    xfer    = 1'b0;
    sel     = cur_q;
    ready_c = '0;

    if (!stall) begin
      if (state_q == IDLE) begin
        if (pick_found) begin
          state_d = BURST;
          cur_d   = pick_idx;
          cnt_d   = CW'(1);
          xfer    = 1'b1;
          sel     = pick_idx;
        end
      end else if (!rel) begin
        cnt_d = cnt_q + 1'b1;
        xfer  = 1'b1;
        sel   = cur_q;
      end else begin
        // Release: hand over in the same cycle so no bubble appears.
        ptr_d = cur_inc;
        if (pick_found) begin
          cur_d = pick_idx;
          cnt_d = CW'(1);
          xfer  = 1'b1;
          sel   = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
    end

    if (xfer) begin
      ready_c[sel] = 1'b1;
    end
  end

  always_comb begin
    wr_en_d    = xfer;
    data_out_d = xfer ? Data_in[sel] : data_out_q;
    grant_id_d = xfer ? sel : grant_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      wr_en_q    <= 1'b0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      wr_en_q    <= wr_en_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Ready is Mealy; mask it so nothing strobes while reset is held.
  assign Ready    = rst_n ? ready_c : '0;
  assign Data_out = data_out_q;
  assign wr_en    = wr_en_q;
  assign Grant_id = grant_id_q;

endmodule

// File: tb/tb_burst_rr_arbiter.sv
module tb_burst_rr_arbiter;
  import arb_pkg::*;

  localparam int N  = 16;
  localparam int RS = 16;
  localparam int MB = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           valid;
  logic [N-1:0][RS-1:0]   data_in;
  logic                   stall;
  logic [N-1:0]           ready;
  logic [RS-1:0]          data_out;
  logic                   wr_en;
  logic [3:0]             grant_id;
`ifdef ARB_URGENT_EN
  logic [N-1:0]           urgent;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  burst_rr_arbiter #(.NUM_CH(N), .REQ_SIZE(RS), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Valid    (valid),
    .Data_in  (data_in),
`ifdef ARB_URGENT_EN
    .Urgent   (urgent),
`endif
    .stall    (stall),
    .Ready    (ready),
    .Data_out (data_out),
    .wr_en    (wr_en),
    .Grant_id (grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle starting at posedge+1: check Ready before the edge, then the
  // registered outputs after it. ch < 0 means no transfer expected.
  task automatic cyc(input string tag, input int ch);
    logic [31:0] exp_rdy;
    exp_rdy = (ch < 0) ? 32'd0 : (32'd1 << ch);
    #2;
    chk({tag, ".ready"}, 32'(ready), exp_rdy);
    @(posedge clk);
    #1;
    if (ch < 0) begin
      chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
    end else begin
      chk({tag, ".wr_en"}, 32'(wr_en), 32'd1);
      chk({tag, ".gid"}, 32'(grant_id), 32'(ch));
      chk({tag, ".data"}, 32'(data_out), 32'hA000 + 32'(ch));
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_ready"}, 32'(ready), 32'd0);
    chk({tag, ".rst_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, ".rst_data"}, 32'(data_out), 32'd0);
    chk({tag, ".rst_gid"}, 32'(grant_id), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int seq2 [13];
    seq2 = '{0, 0, 0, 0, 8, 8, 8, 8, 15, 15, 15, 15, 0};

    rst_n = 1'b0;
    valid = '0;
    stall = 1'b0;
`ifdef ARB_URGENT_EN
    urgent = '0;
`endif
    for (int i = 0; i < N; i++) data_in[i] = 16'hA000 + 16'(i);

    // Reset state, then one idle cycle with nothing requested.
    do_reset("init");
    cyc("idle", -1);

    // 1: single source keeps the port across forced rotations with no gap.
    valid = 16'h0001;
    for (int i = 0; i < 8; i++) cyc($sformatf("t1c%0d", i), 0);
    valid = '0;
    cyc("t1end", -1);

    // 2: rotation ch0 x4, ch8 x4, ch15 x4, ch0. Ready is masked in reset.
    valid = 16'h8101;
    do_reset("t2");
    for (int i = 0; i < 13; i++) cyc($sformatf("t2c%0d", i), seq2[i]);
    valid = '0;
    cyc("t2end", -1);

    // 3: early release of ch3 hands straight over to ch5.
    do_reset("t3");
    valid = (16'h1 << 3) | (16'h1 << 5);
    cyc("t3c0", 3);
    cyc("t3c1", 3);
    valid = 16'h1 << 5;
    cyc("t3c2", 5);
    chk("t3.ptr", 32'(dut.ptr_q), 32'd4);
    valid = '0;
    cyc("t3end", -1);

    // 4: stall mid-burst at cnt=2, then two more words, then ch6.
    do_reset("t4");
    valid = (16'h1 << 2) | (16'h1 << 6);
    cyc("t4c0", 2);
    cyc("t4c1", 2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("t4s%0d", i), -1);
      chk($sformatf("t4s%0d.gid", i), 32'(grant_id), 32'd2);
      chk($sformatf("t4s%0d.data", i), 32'(data_out), 32'hA002);
      chk($sformatf("t4s%0d.cnt", i), 32'(dut.cnt_q), 32'd2);
    end
    stall = 1'b0;
    cyc("t4c2", 2);
    cyc("t4c3", 2);
    cyc("t4c4", 6);

    // 5: asynchronous reset between edges during the ch6 burst.
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.ready", 32'(ready), 32'd0);
    chk("t5.wr_en", 32'(wr_en), 32'd0);
    chk("t5.data", 32'(data_out), 32'd0);
    chk("t5.gid", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("t5c0", 2);
    valid = '0;
    cyc("t5end", -1);

`ifdef ARB_URGENT_EN
    // 6: urgent ch9 gets in after one more ch1 word, ahead of ch2.
    do_reset("t6");
    valid = (16'h1 << 1) | (16'h1 << 2);
    cyc("t6c0", 1);
    cyc("t6c1", 1);
    valid = valid | (16'h1 << 9);
    urgent = 16'h1 << 9;
    cyc("t6c2", 1);
    cyc("t6c3", 9);
    urgent = '0;
    valid = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
